// File: rtl/pipe_ctrl.sv
// pipe_ctrl - pipeline hazard controller for the five-stage RV32I core.
//
// Watches the decode stage, the ID/EX register and the multi-cycle divider,
// and drives hold/flush controls into the PC, IF/ID and ID/EX registers.
// The fixed priority in RUN is: bus hold > EX jump > divide start > load-use.
// A jump resolved while the bus freezes the pipeline is parked in a pending
// register and replayed on the first cycle the bus hold drops.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   rs1/rs2_addr_id, _ren_id  source registers of the instruction in ID
//   rd_addr_ex, rd_wen_ex     destination of the instruction in EX
//   is_load_ex                instruction in EX is a load
//   jump_en_ex, jump_addr_ex  taken branch/jump resolved in EX
//   div_start, div_done       divider issue / result pulses
//   bus_hold                  bus not ready, freeze the pipeline
//   hold_pc, hold_if_id, hold_id_ex   register keeps its value
//   flush_if_id, flush_id_ex          register loads a NOP
//   jump_en_o, jump_addr_o    PC redirect (address is 0 when not redirecting)
//   div_timeout               one-cycle pulse on forced divide-wait exit
//   stall_cnt                 count of cycles with hold_pc high (wraps)
//   state_dbg                 current controller state, for observation
//
// Handshake note: there is no valid/ready pairing here; every control
// output is a level that applies to the current cycle only, computed
// combinationally from the registered state and this cycle's inputs.
module pipe_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_addr_id,
  input  logic [4:0]       rs2_addr_id,
  input  logic             rs1_ren_id,
  input  logic             rs2_ren_id,
  input  logic [4:0]       rd_addr_ex,
  input  logic             rd_wen_ex,
  input  logic             is_load_ex,
  input  logic             jump_en_ex,
  input  logic [31:0]      jump_addr_ex,
  input  logic             div_start,
  input  logic             div_done,
  input  logic             bus_hold,
  output logic             hold_pc,
  output logic             hold_if_id,
  output logic             hold_id_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             div_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_dbg
);

  localparam int TW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DIV_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    BUS_WAIT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          pend, pend_nxt;
  logic [31:0]   pend_addr, pend_addr_nxt;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic          lu;

  assign state_dbg = state;

  // Load-use: the load in EX writes a register the ID instruction reads.
  // x0 is never a real dependency.
  assign lu = is_load_ex && rd_wen_ex && (rd_addr_ex != 5'd0) &&
              ((rs1_ren_id && (rs1_addr_id == rd_addr_ex)) ||
               (rs2_ren_id && (rs2_addr_id == rd_addr_ex)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      pend      <= 1'b0;
      pend_addr <= '0;
      tmo_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pend      <= pend_nxt;
      pend_addr <= pend_addr_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      if (hold_pc) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend;
    pend_addr_nxt = pend_addr;
    tmo_cnt_nxt   = tmo_cnt;
    hold_pc       = 1'b0;
    hold_if_id    = 1'b0;
    hold_id_ex    = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    jump_en_o     = 1'b0;
    jump_addr_o   = '0;
    div_timeout   = 1'b0;

    unique case (state)
      RUN: begin
        if (bus_hold) begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
          if (jump_en_ex) begin
            pend_nxt      = 1'b1;
            pend_addr_nxt = jump_addr_ex;
          end
          state_nxt = BUS_WAIT;
        end else if (jump_en_ex) begin
          // The jump squashes the two younger instructions, so a hazard
          // or divide they carry is irrelevant.
          jump_en_o   = 1'b1;
          jump_addr_o = jump_addr_ex;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (div_start) begin
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          hold_id_ex  = 1'b1;
          tmo_cnt_nxt = '0;
          state_nxt   = DIV_WAIT;
        end else if (lu) begin
          // One bubble: ID stays put, EX gets a NOP, the load moves on.
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          flush_id_ex = 1'b1;
        end
      end

      DIV_WAIT: begin
        hold_pc     = 1'b1;
        hold_if_id  = 1'b1;
        hold_id_ex  = 1'b1;
        tmo_cnt_nxt = tmo_cnt + TW'(1);
        if (div_done) begin
          state_nxt = RUN;
        end else if (tmo_cnt == TMO_LAST) begin
          div_timeout = 1'b1;
          state_nxt   = RUN;
        end
      end

      BUS_WAIT: begin
        if (bus_hold) begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
        end else begin
          if (pend) begin
            jump_en_o   = 1'b1;
            jump_addr_o = pend_addr;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pend_nxt    = 1'b0;
          end
          state_nxt = RUN;
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase

    // Everything is quiet while reset is held, whatever the inputs do.
    if (!rst) begin
      hold_pc     = 1'b0;
      hold_if_id  = 1'b0;
      hold_id_ex  = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      jump_en_o   = 1'b0;
      jump_addr_o = '0;
      div_timeout = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl - self-checking bench for pipe_ctrl.
// Directed scenarios compare against hand-derived constants; the random
// scenario compares against a behavioural model of the pipeline that tracks
// "frozen by bus", "waiting on divider for k cycles" and a queue of jumps
// waiting to be replayed.
module tb_pipe_ctrl;

  localparam int DIV_TIMEOUT = 64;
  localparam int CNT_W       = 32;

  // Output vector order: hold_pc, hold_if_id, hold_id_ex,
  //                      flush_if_id, flush_id_ex, jump_en_o, div_timeout
  localparam logic [6:0] V_NONE  = 7'b000_00_0_0;
  localparam logic [6:0] V_HOLD3 = 7'b111_00_0_0;
  localparam logic [6:0] V_LU    = 7'b110_01_0_0;
  localparam logic [6:0] V_JMP   = 7'b000_11_1_0;
  localparam logic [6:0] V_TMO   = 7'b111_00_0_1;

  logic             clk;
  logic             rst_n;
  logic [4:0]       rs1_addr_id, rs2_addr_id;
  logic             rs1_ren_id, rs2_ren_id;
  logic [4:0]       rd_addr_ex;
  logic             rd_wen_ex, is_load_ex;
  logic             jump_en_ex;
  logic [31:0]      jump_addr_ex;
  logic             div_start, div_done, bus_hold;
  logic             hold_pc, hold_if_id, hold_id_ex;
  logic             flush_if_id, flush_id_ex;
  logic             jump_en_o;
  logic [31:0]      jump_addr_o;
  logic             div_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state_dbg;

  int total = 0;
  int bad   = 0;

  logic [6:0]       got_vec, exp_vec;
  logic [31:0]      got_addr, exp_addr;
  logic [CNT_W-1:0] got_cnt;

  // Behavioural model state.
  bit               m_frozen;     // pipeline frozen by the bus
  bit               m_dividing;   // waiting on the divider
  int               m_div_cycle;  // 1-based count of wait cycles so far
  logic [31:0]      exp_q[$];     // jumps waiting to be replayed
  logic [CNT_W-1:0] m_stall;

  pipe_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst_n),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .rs1_ren_id(rs1_ren_id), .rs2_ren_id(rs2_ren_id),
    .rd_addr_ex(rd_addr_ex), .rd_wen_ex(rd_wen_ex), .is_load_ex(is_load_ex),
    .jump_en_ex(jump_en_ex), .jump_addr_ex(jump_addr_ex),
    .div_start(div_start), .div_done(div_done), .bus_hold(bus_hold),
    .hold_pc(hold_pc), .hold_if_id(hold_if_id), .hold_id_ex(hold_id_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .div_timeout(div_timeout), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rs1_addr_id = '0; rs2_addr_id = '0; rs1_ren_id = 0; rs2_ren_id = 0;
    rd_addr_ex = '0; rd_wen_ex = 0; is_load_ex = 0;
    jump_en_ex = 0; jump_addr_ex = '0;
    div_start = 0; div_done = 0; bus_hold = 0;
  endtask

  task automatic model_reset();
    m_frozen = 0; m_dividing = 0; m_div_cycle = 0;
    exp_q.delete(); m_stall = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic sample();
    @(negedge clk);
    got_vec  = {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex,
                jump_en_o, div_timeout};
    got_addr = jump_addr_o;
    got_cnt  = stall_cnt;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    bus_hold     = ($urandom_range(0, 99) < 15);
    jump_en_ex   = ($urandom_range(0, 99) < 15);
    jump_addr_ex = $urandom;
    div_start    = ($urandom_range(0, 99) < 6);
    div_done     = ($urandom_range(0, 99) < 12);
    is_load_ex   = 1'($urandom_range(0, 1));
    rd_wen_ex    = 1'($urandom_range(0, 1));
    rd_addr_ex   = 5'($urandom_range(0, 3));
    rs1_addr_id  = 5'($urandom_range(0, 3));
    rs2_addr_id  = 5'($urandom_range(0, 3));
    rs1_ren_id   = 1'($urandom_range(0, 1));
    rs2_ren_id   = 1'($urandom_range(0, 1));
  endtask

  // ---------------- reference model ----------------
  function automatic bit load_use();
    return is_load_ex && rd_wen_ex && rd_addr_ex != 0 &&
           ((rs1_ren_id && rs1_addr_id == rd_addr_ex) ||
            (rs2_ren_id && rs2_addr_id == rd_addr_ex));
  endfunction

  // What the pipeline controls should be this cycle.
  task automatic model_eval();
    exp_vec  = V_NONE;
    exp_addr = '0;
    if (m_frozen) begin
      if (bus_hold) exp_vec = V_HOLD3;
      else if (exp_q.size() > 0) begin
        exp_vec  = V_JMP;
        exp_addr = exp_q[0];
      end
    end else if (m_dividing) begin
      exp_vec = (!div_done && m_div_cycle == DIV_TIMEOUT) ? V_TMO : V_HOLD3;
    end else if (bus_hold) exp_vec = V_HOLD3;
    else if (jump_en_ex) begin
      exp_vec  = V_JMP;
      exp_addr = jump_addr_ex;
    end else if (div_start) exp_vec = V_HOLD3;
    else if (load_use()) exp_vec = V_LU;
  endtask

  // Bookkeeping for the clock edge that ends this cycle.
  task automatic model_update();
    if (exp_vec[6]) m_stall = m_stall + 1;
    if (m_frozen) begin
      if (!bus_hold) begin
        m_frozen = 0;
        exp_q.delete();
      end
    end else if (m_dividing) begin
      if (div_done || m_div_cycle == DIV_TIMEOUT) m_dividing = 0;
      else m_div_cycle++;
    end else if (bus_hold) begin
      m_frozen = 1;
      if (jump_en_ex) exp_q.push_back(jump_addr_ex);
    end else if (!jump_en_ex && div_start) begin
      m_dividing  = 1;
      m_div_cycle = 1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    bus_hold = 1; jump_en_ex = 1; jump_addr_ex = 32'hdead_beef; div_start = 1;
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL reset_outs got=%b exp=%b", got_vec, V_NONE); end
    total++; if (got_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", got_addr); end
    total++; if (got_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", got_cnt); end
    apply_reset();
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL reset_idle got=%b exp=%b", got_vec, V_NONE); end
  endtask

  task automatic test_load_use();
    apply_reset();
    is_load_ex = 1; rd_wen_ex = 1; rd_addr_ex = 5; rs1_addr_id = 5; rs1_ren_id = 1;
    sample();
    total++; if (got_vec !== V_LU) begin bad++; $display("FAIL lu_bubble got=%b exp=%b", got_vec, V_LU); end
    advance();
    is_load_ex = 0;  // the load has moved on; hazard gone
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL lu_clears got=%b exp=%b", got_vec, V_NONE); end
    advance();
    is_load_ex = 1; rd_addr_ex = 0; rs1_addr_id = 0;
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL lu_x0 got=%b exp=%b", got_vec, V_NONE); end
    advance();
    rd_addr_ex = 7; rs1_addr_id = 7; rs1_ren_id = 0; rs2_addr_id = 7; rs2_ren_id = 1;
    sample();
    total++; if (got_vec !== V_LU) begin bad++; $display("FAIL lu_rs2 got=%b exp=%b", got_vec, V_LU); end
    advance();
    rs2_ren_id = 0;
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL lu_noren got=%b exp=%b", got_vec, V_NONE); end
    total++; if (got_cnt !== 2) begin bad++; $display("FAIL lu_cnt got=%0d exp=2", got_cnt); end
  endtask

  task automatic test_jump_priority();
    apply_reset();
    is_load_ex = 1; rd_wen_ex = 1; rd_addr_ex = 5; rs1_addr_id = 5; rs1_ren_id = 1;
    div_start = 1; jump_en_ex = 1; jump_addr_ex = 32'h100;
    sample();
    total++; if (got_vec !== V_JMP) begin bad++; $display("FAIL jump_outs got=%b exp=%b", got_vec, V_JMP); end
    total++; if (got_addr !== 32'h100) begin bad++; $display("FAIL jump_addr got=%h exp=100", got_addr); end
    advance();
    drive_idle();
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL jump_after got=%b exp=%b", got_vec, V_NONE); end
    total++; if (got_addr !== 32'h0) begin bad++; $display("FAIL jump_addr_zero got=%h exp=0", got_addr); end
    total++; if (got_cnt !== 0) begin bad++; $display("FAIL jump_cnt got=%0d exp=0", got_cnt); end
  endtask

  task automatic test_div_done();
    apply_reset();
    div_start = 1;
    for (int c = 0; c <= 5; c++) begin
      div_done = (c == 5);
      sample();
      total++; if (got_vec !== V_HOLD3) begin bad++; $display("FAIL div_hold c=%0d got=%b exp=%b", c, got_vec, V_HOLD3); end
      advance();
      div_start = 0;
    end
    div_done = 0;
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL div_release got=%b exp=%b", got_vec, V_NONE); end
    total++; if (got_cnt !== 6) begin bad++; $display("FAIL div_cnt got=%0d exp=6", got_cnt); end
    advance();
    div_done = 1;  // stray done while running
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL div_stray_done got=%b exp=%b", got_vec, V_NONE); end
    advance();
    div_done = 0;
  endtask

  task automatic test_div_timeout();
    logic [6:0] want;
    apply_reset();
    div_start = 1;
    for (int c = 0; c <= DIV_TIMEOUT; c++) begin
      want = (c == DIV_TIMEOUT) ? V_TMO : V_HOLD3;
      sample();
      total++; if (got_vec !== want) begin bad++; $display("FAIL tmo_wait c=%0d got=%b exp=%b", c, got_vec, want); end
      advance();
      div_start = 0;
    end
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL tmo_release got=%b exp=%b", got_vec, V_NONE); end
    total++; if (got_cnt !== DIV_TIMEOUT + 1) begin bad++; $display("FAIL tmo_cnt got=%0d exp=%0d", got_cnt, DIV_TIMEOUT + 1); end
  endtask

  task automatic test_bus_jump();
    apply_reset();
    bus_hold = 1; jump_en_ex = 1; jump_addr_ex = 32'h80;
    for (int c = 0; c < 3; c++) begin
      sample();
      total++; if (got_vec !== V_HOLD3) begin bad++; $display("FAIL bus_hold c=%0d got=%b exp=%b", c, got_vec, V_HOLD3); end
      total++; if (got_addr !== 32'h0) begin bad++; $display("FAIL bus_addr_idle c=%0d got=%h exp=0", c, got_addr); end
      advance();
    end
    bus_hold = 0; jump_en_ex = 0; jump_addr_ex = '0;
    sample();
    total++; if (got_vec !== V_JMP) begin bad++; $display("FAIL bus_replay got=%b exp=%b", got_vec, V_JMP); end
    total++; if (got_addr !== 32'h80) begin bad++; $display("FAIL bus_replay_addr got=%h exp=80", got_addr); end
    advance();
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL bus_no_double got=%b exp=%b", got_vec, V_NONE); end
    total++; if (got_cnt !== 3) begin bad++; $display("FAIL bus_cnt got=%0d exp=3", got_cnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    div_start = 1;
    advance();
    div_start = 0;
    repeat (3) advance();
    rst_n = 1'b0;
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL rst_div_outs got=%b exp=%b", got_vec, V_NONE); end
    total++; if (got_cnt !== 0) begin bad++; $display("FAIL rst_div_cnt got=%0d exp=0", got_cnt); end
    advance();
    rst_n = 1'b1;
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL rst_div_run got=%b exp=%b", got_vec, V_NONE); end
    advance();
    bus_hold = 1; jump_en_ex = 1; jump_addr_ex = 32'h200;
    advance();
    advance();
    rst_n = 1'b0;
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL rst_bus_outs got=%b exp=%b", got_vec, V_NONE); end
    total++; if (got_cnt !== 0) begin bad++; $display("FAIL rst_bus_cnt got=%0d exp=0", got_cnt); end
    advance();
    drive_idle();
    rst_n = 1'b1;
    sample();
    total++; if (got_vec !== V_NONE) begin bad++; $display("FAIL rst_no_replay got=%b exp=%b", got_vec, V_NONE); end
    total++; if (got_addr !== 32'h0) begin bad++; $display("FAIL rst_no_replay_addr got=%h exp=0", got_addr); end
    advance();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      sample();
      model_eval();
      total++; if (got_vec !== exp_vec) begin bad++; $display("FAIL rnd_outs c=%0d got=%b exp=%b", c, got_vec, exp_vec); end
      total++; if (got_addr !== exp_addr) begin bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, got_addr, exp_addr); end
      total++; if (got_cnt !== m_stall) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, got_cnt, m_stall); end
      model_update();
      advance();
    end
    drive_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    test_reset();
    test_load_use();
    test_jump_priority();
    test_div_done();
    test_div_timeout();
    test_bus_jump();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller for the five-stage RV32I core. Watches the decode stage, the ID/EX register outputs and the multi-cycle divider, and drives hold/flush controls into the PC register, IF/ID and ID/EX pipeline registers. Resolves load-use stalls, EX-stage jump redirects, divider waits and external bus holds with a fixed priority. Redirects that arrive during a bus hold are buffered and replayed when the hold releases.

## Interface
Parameters:
- DIV_TIMEOUT, 64: maximum cycles spent in DIV_WAIT before forced release.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs1_addr_id, rs2_addr_id  in  5 each  source registers of the instruction in ID.
- rs1_ren_id, rs2_ren_id  in  1 each  source register actually read.
- rd_addr_ex  in  5  destination register from the ID/EX register.
- rd_wen_ex  in  1  destination write enable from the ID/EX register.
- is_load_ex  in  1  instruction in EX is a load.
- jump_en_ex  in  1  EX resolved a taken branch or jump.
- jump_addr_ex  in  32  target of that jump.
- div_start  in  1  EX issued a divide (single-cycle pulse).
- div_done  in  1  divider result valid (single-cycle pulse).
- bus_hold  in  1  instruction or data bus not ready; freeze the pipeline.
- hold_pc, hold_if_id, hold_id_ex  out  1 each  register keeps its current value.
- flush_if_id, flush_id_ex  out  1 each  register loads its NOP value (ins = 32'h13, all other fields 0).
- jump_en_o  out  1  PC takes jump_addr_o this cycle.
- jump_addr_o  out  32  redirect target.
- div_timeout  out  1  single-cycle pulse on forced DIV_WAIT exit.
- stall_cnt  out  CNT_W  count of cycles with hold_pc = 1; wraps to 0.

## Operation
- States: RUN, DIV_WAIT, BUS_WAIT. Reset state is RUN.
- Load-use hazard (LU) = is_load_ex & rd_wen_ex & rd_addr_ex != 0 & ((rs1_ren_id & rs1_addr_id == rd_addr_ex) | (rs2_ren_id & rs2_addr_id == rd_addr_ex)).
- RUN, evaluated in priority order:
  - bus_hold: assert all three holds. If jump_en_ex is also high, latch jump_addr_ex into a pending register and set pend. Go to BUS_WAIT.
  - jump_en_ex: assert jump_en_o with jump_addr_o = jump_addr_ex, flush_if_id and flush_id_ex. LU and div_start are ignored. Stay in RUN.
  - div_start: assert hold_pc, hold_if_id and hold_id_ex; load the timeout counter with 0. Go to DIV_WAIT.
  - LU: assert hold_pc, hold_if_id and flush_id_ex (one bubble). Stay in RUN; the hazard clears itself on the next cycle.
- DIV_WAIT:
  - All three holds are asserted every cycle, including the exit cycle.
  - The counter increments each cycle.
  - div_done: go to RUN.
  - Else if counter == DIV_TIMEOUT-1: pulse div_timeout and go to RUN.
  - bus_hold in this state has no additional effect.
- BUS_WAIT:
  - All three holds are asserted while bus_hold = 1.
  - When bus_hold = 0 and pend = 1: assert jump_en_o with the pending address, flush_if_id and flush_id_ex, and clear pend.
  - When bus_hold = 0: go to RUN in the same cycle.
- jump_addr_o = 0 whenever jump_en_o = 0.
- stall_cnt increments on every cycle where hold_pc = 1.

## Timing
- hold, flush and jump outputs are combinational from the current state and inputs. The next-state and pending register update on the rising clk edge.
- LU costs exactly one bubble. A jump costs two flushed slots.
- A divide stalls the pipeline for N+1 cycles, where div_done arrives N cycles after div_start. Maximum stall is DIV_TIMEOUT+1 cycles.
- A buffered jump is issued on the first cycle with bus_hold = 0.
- Reset low at any time:
  - state = RUN, pend = 0, timeout counter = 0, stall_cnt = 0.
  - All outputs are 0 while rst is low.
  - An in-flight divide wait or pending jump is discarded.
- div_done received in RUN is ignored.

## Test plan
- Load x5 (rd_addr_ex=5, is_load_ex=1, rd_wen_ex=1) with rs1_addr_id=5 and rs1_ren_id=1 -> for one cycle hold_pc=hold_if_id=flush_id_ex=1, hold_id_ex=0. Same stimulus with rd_addr_ex=0 -> no stall.
- jump_en_ex=1, jump_addr_ex=0x100, with LU also true -> jump_en_o=1, jump_addr_o=0x100, both flushes=1, holds=0.
- div_start, then div_done 5 cycles later -> holds high for 6 cycles, return to RUN, stall_cnt increases by 6.
- div_start with no div_done and DIV_TIMEOUT=64 -> div_timeout pulses in the 64th DIV_WAIT cycle, holds drop on the next cycle.
- bus_hold together with jump_en_ex=1, jump_addr_ex=0x80, bus_hold held for 3 cycles -> holds for 3 cycles, then on the next cycle jump_en_o=1, jump_addr_o=0x80, both flushes=1.
- rst pulled low during DIV_WAIT and during BUS_WAIT with pend=1 -> all outputs 0, stall_cnt=0. After release the pipeline runs with no replayed jump.
